// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC execution/control core: opcodes, ALU functions,
// FSM states, datapath select encodings and status flag bit positions.
package sisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ALU  = 4'b0001;
  localparam logic [3:0] OP_ALUI = 4'b0010;
  localparam logic [3:0] OP_LOD  = 4'b0011;
  localparam logic [3:0] OP_STR  = 4'b0100;
  localparam logic [3:0] OP_SWP  = 4'b0101;
  localparam logic [3:0] OP_BRA  = 4'b0110;
  localparam logic [3:0] OP_BRR  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_BNR  = 4'b1001;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [3:0] FN_ADD = 4'b0001;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0011;
  localparam logic [3:0] FN_OR  = 4'b0100;
  localparam logic [3:0] FN_XOR = 4'b0101;
  localparam logic [3:0] FN_NOT = 4'b0110;
  localparam logic [3:0] FN_SHL = 4'b0111;
  localparam logic [3:0] FN_SHR = 4'b1000;

  typedef enum logic [2:0] {
    ST_START0,
    ST_START1,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_DM  = 2'b01;
  localparam logic [1:0] WB_RSA = 2'b10;
  localparam logic [1:0] WB_RSB = 2'b11;

  localparam logic [1:0] MM_ALU = 2'b00;
  localparam logic [1:0] MM_IMM = 2'b01;
  localparam logic [1:0] MM_RSA = 2'b10;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  // Load/store address mode to data-memory address select; mode 11 aliases 00.
  function automatic logic [1:0] addr_mode_sel(input logic [1:0] mode);
    case (mode)
      2'b01:   return MM_RSA;
      2'b10:   return MM_ALU;
      default: return MM_IMM;
    endcase
  endfunction

endpackage

// File: rtl/sisc_alu.sv
// Combinational 32-bit ALU for SISC: B-operand mux, function select and {C,V,N,Z} flags.
// Load/store reuse the adder for rs+imm; swap passes rs straight through.
module sisc_alu
  import sisc_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [3:0]  mm,
  input  logic [15:0] imm,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [3:0]  fn;
  logic [31:0] op_b;
  logic [31:0] b_add;
  logic [32:0] sum;
  logic        is_sub;
  logic        is_arith;

  function automatic logic add_ovf(input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   input logic signed [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  always_comb begin
    fn   = mm;
    op_b = rsb;
    case (opcode)
      OP_ALUI: op_b = {16'b0, imm};
      OP_LOD, OP_STR: begin
        fn   = FN_ADD;
        op_b = {16'b0, imm};
      end
      OP_SWP: begin
        fn   = FN_OR;
        op_b = '0;
      end
      default: ;
    endcase
  end

  // Subtraction is A + ~B + 1 so carry-out means "no borrow".
  assign is_sub   = (fn == FN_SUB);
  assign is_arith = (fn == FN_ADD) || is_sub;
  assign b_add    = is_sub ? ~op_b : op_b;
  assign sum      = {1'b0, rsa} + {1'b0, b_add} + {32'b0, is_sub};

  always_comb begin
    case (fn)
      FN_ADD, FN_SUB: result = sum[31:0];
      FN_AND:         result = rsa & op_b;
      FN_OR:          result = rsa | op_b;
      FN_XOR:         result = rsa ^ op_b;
      FN_NOT:         result = ~rsa;
      FN_SHL:         result = rsa << op_b[4:0];
      FN_SHR:         result = rsa >> op_b[4:0];
      default:        result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[31];
    flags[FLAG_C] = is_arith && sum[32];
    flags[FLAG_V] = is_arith && add_ovf(rsa, b_add, sum[31:0]);
  end

endmodule

// File: rtl/sisc_exec_ctrl.sv
// SISC execution/control core: multi-cycle FSM, registered ALU result and status, branch target.
// Define SISC_SWP_EN to enable the register/register swap instruction (opcode 0101).
module sisc_exec_ctrl
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic [3:0]  opcode,
  input  logic [3:0]  mm,
  input  logic [15:0] imm,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  input  logic [15:0] pc,
  output logic [31:0] alu_result,
  output logic [3:0]  stat,
  output logic [15:0] br_addr,
  output logic        br_sel,
  output logic        pc_sel,
  output logic        pc_write,
  output logic        pc_rst,
  output logic        ir_load,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        wr_sel,
  output logic        rb_sel,
  output logic [1:0]  mm_sel,
  output logic        dm_we
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic        is_alu;
  logic        is_lod;
  logic        is_str;
  logic        is_swp;
  logic        is_br_pos;
  logic        is_br_neg;
  logic        br_taken;
  logic        alu_upd;
  logic [1:0]  addr_sel;

  sisc_alu u_alu (
    .opcode (opcode),
    .mm     (mm),
    .imm    (imm),
    .rsa    (rsa),
    .rsb    (rsb),
    .result (alu_out),
    .flags  (alu_flags)
  );

  assign is_alu    = (opcode == OP_ALU) || (opcode == OP_ALUI);
  assign is_lod    = (opcode == OP_LOD);
  assign is_str    = (opcode == OP_STR);
  assign is_br_pos = (opcode == OP_BRA) || (opcode == OP_BRR);
  assign is_br_neg = (opcode == OP_BNE) || (opcode == OP_BNR);
`ifdef SISC_SWP_EN
  assign is_swp    = (opcode == OP_SWP);
`else
  assign is_swp    = 1'b0;
`endif

  // Branches test the flags left by the previous ALU instruction.
  assign br_taken = (is_br_pos && (|(stat & mm))) || (is_br_neg && !(|(stat & mm)));
  assign alu_upd  = is_alu || is_lod || is_str || is_swp;
  assign addr_sel = addr_mode_sel(mm[1:0]);
  assign br_addr  = br_sel ? imm : pc + imm;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state      <= ST_START0;
      alu_result <= '0;
      stat       <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_EXECUTE) begin
        if (alu_upd) alu_result <= alu_out;
        if (is_alu)  stat       <= alu_flags;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_rst    = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    br_sel    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    wr_sel    = 1'b0;
    rb_sel    = 1'b0;
    mm_sel    = MM_ALU;
    dm_we     = 1'b0;
    case (state)
      ST_START0: begin
        pc_rst    = 1'b1;
        state_nxt = ST_START1;
      end
      ST_START1: state_nxt = ST_FETCH;
      ST_FETCH: begin
        ir_load   = 1'b1;
        pc_write  = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        br_sel = (opcode == OP_BRA) || (opcode == OP_BNE);
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
        end
        state_nxt = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        rb_sel    = is_str;
        state_nxt = ST_MEM;
      end
      ST_MEM: begin
        if (is_lod || is_str) mm_sel = addr_sel;
        dm_we  = is_str;
        rb_sel = is_str;
        // Swap first half: rs <- old rd read through the second port.
        if (is_swp) begin
          rf_we  = 1'b1;
          rb_sel = 1'b1;
          wb_sel = WB_RSB;
          wr_sel = 1'b1;
        end
        state_nxt = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        if (is_alu || is_swp) rf_we = 1'b1;
        if (is_lod) begin
          rf_we  = 1'b1;
          wb_sel = WB_DM;
          mm_sel = addr_sel;
        end
        state_nxt = ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_START0;
    endcase
  end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Randomized self-checking bench for sisc_exec_ctrl against a cycle-phase reference model.
module tb_sisc_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic [3:0]  opcode = '0;
  logic [3:0]  mm = '0;
  logic [15:0] imm = '0;
  logic [31:0] rsa = '0;
  logic [31:0] rsb = '0;
  logic [15:0] pc = '0;
  logic [31:0] alu_result;
  logic [3:0]  stat;
  logic [15:0] br_addr;
  logic        br_sel, pc_sel, pc_write, pc_rst, ir_load, rf_we, wr_sel, rb_sel, dm_we;
  logic [1:0]  wb_sel, mm_sel;

  sisc_exec_ctrl dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .imm(imm), .rsa(rsa), .rsb(rsb),
    .pc(pc), .alu_result(alu_result), .stat(stat), .br_addr(br_addr), .br_sel(br_sel),
    .pc_sel(pc_sel), .pc_write(pc_write), .pc_rst(pc_rst), .ir_load(ir_load), .rf_we(rf_we),
    .wb_sel(wb_sel), .wr_sel(wr_sel), .rb_sel(rb_sel), .mm_sel(mm_sel), .dm_we(dm_we)
  );

  always #5 clk = ~clk;

`ifdef SISC_SWP_EN
  localparam bit SWP_EN = 1'b1;
`else
  localparam bit SWP_EN = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_alu;
  logic        m_alu_known;
  logic [3:0]  m_stat;
  logic [15:0] dec_br_addr;
  logic        dec_pc_write;
  logic [3:0]  ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd14};

  wire [12:0] ctrl = {pc_rst, ir_load, pc_write, pc_sel, rf_we, wb_sel, wr_sel, rb_sel,
                      mm_sel, dm_we, br_sel};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected control outputs by instruction phase: -2 START0, -1 START1,
  // 0 FETCH .. 4 WRITEBACK, anything else = halted.
  function automatic logic [12:0] exp_ctrl(input int phase, input logic [3:0] op,
                                           input logic [3:0] m, input logic [3:0] st);
    logic prst, irl, pcw, pcs, we, wrs, rbs, dwe, brs;
    logic [1:0] wbs, mms, amode;
    bit alu, lod, str, swp, pos, neg;
    prst = 0; irl = 0; pcw = 0; pcs = 0; we = 0; wrs = 0; rbs = 0; dwe = 0; brs = 0;
    wbs = 0; mms = 0;
    alu = (op == 1) || (op == 2);
    lod = (op == 3);
    str = (op == 4);
    swp = (op == 5) && SWP_EN;
    pos = (op == 6) || (op == 7);
    neg = (op == 8) || (op == 9);
    if (m[1:0] == 2'b01)      amode = 2'b10;
    else if (m[1:0] == 2'b10) amode = 2'b00;
    else                      amode = 2'b01;
    case (phase)
      -2: prst = 1;
      0: begin irl = 1; pcw = 1; end
      1: if (pos || neg) begin
        brs = (op == 6) || (op == 8);
        if ((pos && (st & m) != 0) || (neg && (st & m) == 0)) begin pcw = 1; pcs = 1; end
      end
      2: rbs = str;
      3: begin
        if (str) begin dwe = 1; rbs = 1; mms = amode; end
        if (lod) mms = amode;
        if (swp) begin we = 1; rbs = 1; wbs = 2'b11; wrs = 1; end
      end
      4: begin
        if (alu || swp) we = 1;
        if (lod) begin we = 1; wbs = 2'b01; mms = amode; end
      end
      default: ;
    endcase
    return {prst, irl, pcw, pcs, we, wbs, wrs, rbs, mms, dwe, brs};
  endfunction

  // Architectural effect of the EXECUTE edge.
  task automatic model_exec(input logic [3:0] op, input logic [3:0] m, input logic [15:0] im,
                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb, r;
    logic c, v;
    longint s;
    if (op == 1 || op == 2) begin
      bb = (op == 2) ? {16'h0, im} : b;
      c = 0; v = 0;
      case (m)
        1: begin
          r = a + bb;
          c = ({1'b0, a} + {1'b0, bb}) > 33'h0_FFFF_FFFF;
          s = longint'($signed(a)) + longint'($signed(bb));
          v = (s > SMAX) || (s < SMIN);
        end
        2: begin
          r = a - bb;
          c = (a >= bb);
          s = longint'($signed(a)) - longint'($signed(bb));
          v = (s > SMAX) || (s < SMIN);
        end
        3: r = a & bb;
        4: r = a | bb;
        5: r = a ^ bb;
        6: r = ~a;
        7: r = a << bb[4:0];
        8: r = a >> bb[4:0];
        default: r = 0;
      endcase
      m_stat = {c, v, r[31], (r == 0)};
      m_alu = r;
      m_alu_known = 1;
    end else if ((op == 3 || op == 4) && m[1:0] == 2'b10) begin
      m_alu = a + {16'h0, im};
      m_alu_known = 1;
    end else if (op == 5 && SWP_EN) begin
      m_alu = a;
      m_alu_known = 1;
    end else begin
      m_alu_known = 0;
    end
  endtask

  task automatic check_cycle(input int phase, input logic [3:0] op, input logic [3:0] m);
    check($sformatf("ctrl_op%0d_ph%0d", op, phase), {19'b0, ctrl}, {19'b0, exp_ctrl(phase, op, m, m_stat)});
    check($sformatf("stat_ph%0d", phase), {28'b0, stat}, {28'b0, m_stat});
    if (m_alu_known) check($sformatf("alu_ph%0d", phase), alu_result, m_alu);
  endtask

  task automatic do_reset();
    rst_f = 1; opcode = 0; mm = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_f = 0;
    m_alu = 0; m_alu_known = 1; m_stat = 0;
    @(negedge clk); check_cycle(-2, 4'd0, 4'd0);
    @(posedge clk); #1;
    @(negedge clk); check_cycle(-1, 4'd0, 4'd0);
    @(posedge clk); #1;
  endtask

  // Starts just after the edge entering FETCH; abort_ph >= 0 stops after that phase's check.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [15:0] im,
                           input logic [31:0] a, input logic [31:0] b, input logic [15:0] p,
                           input int abort_ph);
    opcode = op; mm = m; imm = im; rsa = a; rsb = b; pc = p;
    for (int ph = 0; ph < 5; ph++) begin
      @(negedge clk);
      check_cycle(ph, op, m);
      if (ph == 1) begin
        dec_br_addr = br_addr;
        dec_pc_write = pc_write;
        if (op >= 6 && op <= 9)
          check("br_addr", {16'b0, br_addr}, {16'b0, ((op == 6 || op == 8) ? im : p + im)});
      end
      if (ph == abort_ph) return;
      @(posedge clk); #1;
      if (ph == 2) model_exec(op, m, im, a, b);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_alu = 0; m_alu_known = 0; m_stat = 0; dec_br_addr = 0; dec_pc_write = 0;
    do_reset();

    run_instr(4'd1, 4'd1, 16'h0, 32'h7FFF_FFFF, 32'h1, 16'h0, -1);
    check("add_ovf_res", alu_result, 32'h8000_0000);
    check("add_ovf_stat", {28'b0, stat}, 32'h6);
    run_instr(4'd1, 4'd1, 16'h0, 32'hFFFF_FFFF, 32'h1, 16'h0, -1);
    check("add_carry_stat", {28'b0, stat}, 32'h9);
    run_instr(4'd1, 4'd2, 16'h0, 32'd5, 32'd5, 16'h0, -1);
    check("sub_zero_stat", {28'b0, stat}, 32'h9);

    run_instr(4'd6, 4'd1, 16'h0020, 32'h0, 32'h0, 16'h0005, -1);
    check("bra_target", {16'b0, dec_br_addr}, 32'h20);
    check("bra_taken", {31'b0, dec_pc_write}, 32'h1);
    run_instr(4'd8, 4'd1, 16'h0020, 32'h0, 32'h0, 16'h0005, -1);
    check("bne_not_taken", {31'b0, dec_pc_write}, 32'h0);
    run_instr(4'd7, 4'd1, 16'hFFFE, 32'h0, 32'h0, 16'h0011, -1);
    check("brr_target", {16'b0, dec_br_addr}, 32'h000F);

    run_instr(4'd4, 4'b0010, 16'd5, 32'd4, 32'h1234, 16'h0, -1);
    check("str_addr", alu_result, 32'd9);
    run_instr(4'd5, 4'd0, 16'h0, 32'd2, 32'd3, 16'h0, -1);
    if (SWP_EN) check("swp_res", alu_result, 32'd2);
    run_instr(4'd0, 4'd3, 16'h0, 32'h0, 32'h0, 16'h0, -1);

    // Reset in the middle of an instruction after flags were changed.
    run_instr(4'd1, 4'd2, 16'h0, 32'd3, 32'd3, 16'h0, 3);
    do_reset();
    check("rst_mid_stat", {28'b0, stat}, 32'h0);
    check("rst_mid_alu", alu_result, 32'h0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] op, m;
      op = ops[$urandom_range(0, 11)];
      m = (op == 1 || op == 2) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      run_instr(op, m, 16'($urandom), rnd32(), rnd32(), 16'($urandom), -1);
    end

    // HLT parks the FSM until reset.
    opcode = 4'hF; mm = 0;
    @(negedge clk); check_cycle(0, 4'hF, 4'd0);
    @(posedge clk); #1;
    @(negedge clk); check_cycle(1, 4'hF, 4'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check_cycle(99, 4'hF, 4'd0);
      @(posedge clk); #1;
    end
    do_reset();
    run_instr(4'd2, 4'd1, 16'h0010, 32'h0000_0005, 32'h0, 16'h0, -1);
    check("post_halt_addi", alu_result, 32'h15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
